// File: rtl/mux_sel_arbiter_if.sv
// Request/grant/select bundle between requesters and the mux arbiter.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       valid;

  modport master (
    output req,
    input  gnt,
    input  s0,
    input  s1,
    input  valid
  );

  modport slave (
    input  req,
    output gnt,
    output s0,
    output s1,
    output valid
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Optional hold limit: define MUX_ARB_HOLD_LIMIT_EN to cap grants at HOLD_MAX.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux_sel_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q,  last_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [3:0]  gnt_q,   gnt_d;
  logic [1:0]  sel_q,   sel_d;
  logic        valid_q, valid_d;

  logic [1:0]  pick;
  logic        limit_en;
  logic        release_c;

  // Scan from last+1 around to last; the nearest set bit wins.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

`ifdef MUX_ARB_HOLD_LIMIT_EN
  assign limit_en = 1'b1;
`else
  assign limit_en = 1'b0;
`endif

  assign pick      = rr_pick(bus.req, last_q);
  assign release_c = !bus.req[owner_q] ||
                     (limit_en && (cnt_q == 8'(HOLD_MAX)));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = BUSY;
          owner_d = pick;
          last_d  = pick;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          cnt_d   = 8'd1;
        end
      end
      BUSY: begin
        if (!release_c) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (|bus.req) begin
          // Sole requester at the limit re-picks itself.
          owner_d = pick;
          last_d  = pick;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          cnt_d   = 8'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (HOLD_MAX=4).
// Limit scenarios run only when MUX_ARB_HOLD_LIMIT_EN is defined.
module tb_mux_sel_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] act;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #2;
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0000_00_0) begin
      n_err++;
      $display("FAIL reset_init act=%b exp=%b", act, 7'b0000_00_0);
    end
    step();
    rst_n   = 1'b1;
    bus.req = 4'b0010;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0010_01_1) begin
      n_err++;
      $display("FAIL reset_first act=%b exp=%b", act, 7'b0010_01_1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0000_00_0) begin
      n_err++;
      $display("FAIL reset_async act=%b exp=%b", act, 7'b0000_00_0);
    end
    step();
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0100_10_1) begin
      n_err++;
      $display("FAIL reset_restart act=%b exp=%b", act, 7'b0100_10_1);
    end
    bus.req = 4'b0000;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0000_10_0) begin
      n_err++;
      $display("FAIL reset_idle act=%b exp=%b", act, 7'b0000_10_0);
    end
  endtask

  task automatic test_single();
    logic [6:0] act;
    bus.req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step();
      act = {bus.gnt, bus.s1, bus.s0, bus.valid};
      n_cmp++;
      if (act !== 7'b0010_01_1) begin
        n_err++;
        $display("FAIL single_hold[%0d] act=%b exp=%b",
                 i, act, 7'b0010_01_1);
      end
    end
    bus.req = 4'b0000;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0000_01_0) begin
      n_err++;
      $display("FAIL single_drop act=%b exp=%b", act, 7'b0000_01_0);
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] act;
    bus.req = 4'b1111;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0100_10_1) begin
      n_err++;
      $display("FAIL simul_pick act=%b exp=%b", act, 7'b0100_10_1);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_early_drop();
    logic [6:0] act;
    do_reset();
    bus.req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      step();
      act = {bus.gnt, bus.s1, bus.s0, bus.valid};
      n_cmp++;
      if (act !== 7'b0001_00_1) begin
        n_err++;
        $display("FAIL early_own[%0d] act=%b exp=%b",
                 i, act, 7'b0001_00_1);
      end
    end
    bus.req = 4'b1000;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b1000_11_1) begin
      n_err++;
      $display("FAIL early_handoff act=%b exp=%b", act, 7'b1000_11_1);
    end
    bus.req = 4'b0000;
    step();
  endtask

`ifdef MUX_ARB_HOLD_LIMIT_EN
  task automatic test_round_robin();
    logic [6:0] act;
    logic [6:0] exp;
    logic [1:0] idx;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      idx = 2'((k / 4) % 4);
      exp = {4'b0001 << idx, idx, 1'b1};
      act = {bus.gnt, bus.s1, bus.s0, bus.valid};
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL rr[%0d] act=%b exp=%b", k, act, exp);
      end
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_sole_limit();
    logic [6:0] act;
    do_reset();
    bus.req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      act = {bus.gnt, bus.s1, bus.s0, bus.valid};
      n_cmp++;
      if (act !== 7'b0001_00_1) begin
        n_err++;
        $display("FAIL sole[%0d] act=%b exp=%b",
                 k, act, 7'b0001_00_1);
      end
    end
    bus.req = 4'b0000;
    step();
  endtask
`else
  task automatic test_no_limit();
    logic [6:0] act;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      act = {bus.gnt, bus.s1, bus.s0, bus.valid};
      n_cmp++;
      if (act !== 7'b0001_00_1) begin
        n_err++;
        $display("FAIL nolimit[%0d] act=%b exp=%b",
                 k, act, 7'b0001_00_1);
      end
    end
    bus.req = 4'b1110;
    step();
    act = {bus.gnt, bus.s1, bus.s0, bus.valid};
    n_cmp++;
    if (act !== 7'b0010_01_1) begin
      n_err++;
      $display("FAIL nolimit_drop act=%b exp=%b", act, 7'b0010_01_1);
    end
    bus.req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_early_drop();
`ifdef MUX_ARB_HOLD_LIMIT_EN
    test_round_robin();
    test_sole_limit();
`else
    test_no_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
